// File: rtl/div32x32_iter_if.sv
// div32x32_iter_if: start/busy handshake and operand/result bus of the iterative divider.
//   start, dividend, divisor        : request side (driven by the sequencer)
//   busy, quotient, remainder,
//   div_by_zero                     : response side (driven by the divider)
// Modports: master = sequencer, slave = divider.
interface div32x32_iter_if;
    localparam int unsigned W = 32;

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div32x32_iter.sv
// div32x32_iter: 32-bit unsigned radix-2 restoring divider, one quotient bit per clock.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : div32x32_iter_if.slave (start/dividend/divisor in; busy/quotient/remainder/div_by_zero out)
// Optional feature macro: DIV32X32_EARLY_EXIT_EN -- dividends that fit in 16 bits
// iterate only 16 times (17 busy cycles instead of 33).
module div32x32_iter (
    input  logic              clk,
    input  logic              reset,
    div32x32_iter_if.slave    bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned HW = W / 2;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [W-1:0]   r_d, w_d_nxt;
    logic [W-1:0]   r_q, w_q_nxt;
    // Partial remainder is always < divisor after each step, so 32 bits hold it;
    // the 33rd bit only exists transiently in the shifted trial value.
    logic [W-1:0]   r_r, w_r_nxt;
    logic [W:0]     w_shift;
    logic [W:0]     w_tmp;
    logic           r_busy, w_busy_nxt;
    logic [W-1:0]   r_quotient, w_quotient_nxt;
    logic [W-1:0]   r_remainder, w_remainder_nxt;
    logic           r_div_by_zero, w_div_by_zero_nxt;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_d           <= '0;
            r_q           <= '0;
            r_r           <= '0;
            r_busy        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_d           <= w_d_nxt;
            r_q           <= w_q_nxt;
            r_r           <= w_r_nxt;
            r_busy        <= w_busy_nxt;
            r_quotient    <= w_quotient_nxt;
            r_remainder   <= w_remainder_nxt;
            r_div_by_zero <= w_div_by_zero_nxt;
        end
    end

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_shift = {r_r, r_q[W-1]};
        w_tmp   = w_shift - {1'b0, r_d};
    end

    // Next-state, datapath and result logic
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_d_nxt           = r_d;
        w_q_nxt           = r_q;
        w_r_nxt           = r_r;
        w_quotient_nxt    = r_quotient;
        w_remainder_nxt   = r_remainder;
        w_div_by_zero_nxt = r_div_by_zero;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_d_nxt           = bus.divisor;
                    w_q_nxt           = bus.dividend;
                    w_r_nxt           = '0;
                    w_cnt_nxt         = CW'(W - 1);
                    w_div_by_zero_nxt = 1'b0;
                    w_state_nxt       = (bus.divisor == '0) ? FIN : CALC;
`ifdef DIV32X32_EARLY_EXIT_EN
                    // Upper half is zero: skip the 16 leading zero quotient bits.
                    if ((bus.divisor != '0) && (bus.dividend[W-1:HW] == '0)) begin
                        w_q_nxt   = {bus.dividend[HW-1:0], {HW{1'b0}}};
                        w_cnt_nxt = CW'(HW - 1);
                    end
`endif
                end
            end

            CALC: begin
                if (!w_tmp[W]) begin
                    w_r_nxt = w_tmp[W-1:0];
                    w_q_nxt = {r_q[W-2:0], 1'b1};
                end else begin
                    w_r_nxt = w_shift[W-1:0];
                    w_q_nxt = {r_q[W-2:0], 1'b0};
                end
                if (r_cnt == '0) begin
                    w_state_nxt = FIN;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            FIN: begin
                // q_reg still holds the untouched dividend on the divide-by-zero path.
                if (r_d == '0) begin
                    w_quotient_nxt    = '1;
                    w_remainder_nxt   = r_q;
                    w_div_by_zero_nxt = 1'b1;
                end else begin
                    w_quotient_nxt    = r_q;
                    w_remainder_nxt   = r_r;
                    w_div_by_zero_nxt = 1'b0;
                end
                w_state_nxt = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.busy        = r_busy;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
